// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, mode word and timing defaults
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;

  // full-page burst, sequential, CAS latency 3, burst write
  localparam logic [12:0] MODE_WORD = 13'h037;

  localparam int T_POWER_DEF  = 20000;
  localparam int T_RP_DEF     = 2;
  localparam int T_RFC_DEF    = 7;
  localparam int T_MRD_DEF    = 3;
  localparam int AREF_NUM_DEF = 8;

endpackage

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up sequencer: wait, PRECHARGE ALL, AUTO REFRESH xN, LOAD MODE
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int          T_POWER    = T_POWER_DEF,
  parameter int          T_RP       = T_RP_DEF,
  parameter int          T_RFC      = T_RFC_DEF,
  parameter int          T_MRD      = T_MRD_DEF,
  parameter int          AREF_NUM   = AREF_NUM_DEF,
  parameter logic [12:0] MODE_VALUE = MODE_WORD
) (
  input  logic        clk_100m,
  input  logic        sysrst_n,
  output logic [3:0]  o_init_cmd,
  output logic [1:0]  o_init_ba,
  output logic [12:0] o_init_addr,
  output logic        o_init_done
);

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_AR, S_TRFC, S_MRS, S_TMRD, S_DONE
  } state_t;

  // The counter is already at zero during the first S_WAIT clock, so the wait ends at T_POWER.
  localparam logic [15:0] POWER_END = 16'(T_POWER);
  localparam logic [15:0] RP_END    = 16'(T_RP - 1);
  localparam logic [15:0] RFC_END   = 16'(T_RFC - 1);
  localparam logic [15:0] MRD_END   = 16'(T_MRD - 1);
  localparam logic [3:0]  AREF_LAST = 4'(AREF_NUM);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  aref_cnt, aref_cnt_nxt;
  logic [3:0]  cmd_nxt;
  logic [1:0]  ba_nxt;
  logic [12:0] addr_nxt;

  always_ff @(posedge clk_100m or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state       <= S_WAIT;
      cnt         <= '0;
      aref_cnt    <= '0;
      o_init_cmd  <= CMD_NOP;
      o_init_ba   <= 2'b11;
      o_init_addr <= 13'h1FFF;
      o_init_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      aref_cnt    <= aref_cnt_nxt;
      o_init_cmd  <= cmd_nxt;
      o_init_ba   <= ba_nxt;
      o_init_addr <= addr_nxt;
      o_init_done <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: if (cnt == POWER_END) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_TRP;
      S_TRP:  if (cnt == RP_END) state_nxt = S_AR;
      S_AR:   state_nxt = S_TRFC;
      S_TRFC: if (cnt == RFC_END) state_nxt = (aref_cnt == AREF_LAST) ? S_MRS : S_AR;
      S_MRS:  state_nxt = S_TMRD;
      S_TMRD: if (cnt == MRD_END) state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    cnt_nxt      = cnt;
    aref_cnt_nxt = aref_cnt;
    if (state_nxt != state) cnt_nxt = '0;
    else if (state != S_DONE) cnt_nxt = cnt + 16'd1;
    if (state == S_AR) aref_cnt_nxt = aref_cnt + 4'd1;
  end

  // Outputs are decoded from the next state so the registered command lines up with the state.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    ba_nxt   = 2'b11;
    addr_nxt = 13'h1FFF;
    case (state_nxt)
      S_PRE: begin
        cmd_nxt  = CMD_PRECHARGE;
        addr_nxt = 13'h0400;
      end
      S_AR:  cmd_nxt = CMD_AUTO_REFRESH;
      S_MRS: begin
        cmd_nxt  = CMD_LOAD_MODE;
        ba_nxt   = 2'b00;
        addr_nxt = MODE_VALUE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - directed bench: default, reduced-parameter and mid-sequence-reset runs
module tb_sdram_init_seq;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] LM  = 4'b0000;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic        rst_a, rst_b, rst_c;
  logic [3:0]  cmd_a, cmd_b, cmd_c;
  logic [1:0]  ba_a, ba_b, ba_c;
  logic [12:0] addr_a, addr_b, addr_c;
  logic        done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  sdram_init_seq dut_a (
    .clk_100m(clk_100m), .sysrst_n(rst_a), .o_init_cmd(cmd_a),
    .o_init_ba(ba_a), .o_init_addr(addr_a), .o_init_done(done_a)
  );

  sdram_init_seq #(.T_POWER(10), .AREF_NUM(2)) dut_b (
    .clk_100m(clk_100m), .sysrst_n(rst_b), .o_init_cmd(cmd_b),
    .o_init_ba(ba_b), .o_init_addr(addr_b), .o_init_done(done_b)
  );

  sdram_init_seq #(.T_POWER(10)) dut_c (
    .clk_100m(clk_100m), .sysrst_n(rst_c), .o_init_cmd(cmd_c),
    .o_init_ba(ba_c), .o_init_addr(addr_c), .o_init_done(done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string n, input logic [3:0] cmd, input logic [1:0] ba,
                           input logic [12:0] addr, input logic done);
    chk({n, "_rst_cmd"}, 32'(cmd), 32'(NOP));
    chk({n, "_rst_ba"}, 32'(ba), 32'h3);
    chk({n, "_rst_addr"}, 32'(addr), 32'h1FFF);
    chk({n, "_rst_done"}, 32'(done), 32'h0);
  endtask

  // Expected schedule: PRECHARGE at tp, AREFs every 8 from tp+3, LOAD_MODE next, done 4 later.
  task automatic chk_dut(input string n, input int k, input int tp, input int nar,
                         input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                         input logic done, input logic [3:0] prev);
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    int          mrs;
    mrs    = tp + 3 + 8 * nar;
    e_cmd  = NOP;
    e_ba   = 2'b11;
    e_addr = 13'h1FFF;
    if (k == tp) begin
      e_cmd  = PRE;
      e_addr = 13'h0400;
    end
    for (int j = 0; j < nar; j++)
      if (k == tp + 3 + 8 * j) e_cmd = AR;
    if (k == mrs) begin
      e_cmd  = LM;
      e_ba   = 2'b00;
      e_addr = 13'h037;
    end
    chk($sformatf("%s_cmd@%0d", n, k), 32'(cmd), 32'(e_cmd));
    chk($sformatf("%s_ba@%0d", n, k), 32'(ba), 32'(e_ba));
    chk($sformatf("%s_addr@%0d", n, k), 32'(addr), 32'(e_addr));
    chk($sformatf("%s_done@%0d", n, k), 32'(done), (k >= mrs + 4) ? 32'h1 : 32'h0);
    chk($sformatf("%s_b2b@%0d", n, k), 32'(prev != NOP && cmd != NOP), 32'h0);
  endtask

  initial begin
    int k, kc;
    logic [3:0] prev_a, prev_b, prev_c;
    logic pulsed;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    #12;
    chk_reset("a_hold", cmd_a, ba_a, addr_a, done_a);
    #10;
    chk_reset("b_hold", cmd_b, ba_b, addr_b, done_b);
    chk_reset("c_hold", cmd_c, ba_c, addr_c, done_c);
    #8;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    k = -1;
    kc = -1;
    prev_a = NOP;
    prev_b = NOP;
    prev_c = NOP;
    pulsed = 1'b0;
    repeat (21100) begin
      @(posedge clk_100m);
      #1;
      k++;
      kc++;
      chk_dut("a", k, 20000, 8, cmd_a, ba_a, addr_a, done_a, prev_a);
      chk_dut("b", k, 10, 2, cmd_b, ba_b, addr_b, done_b, prev_b);
      chk_dut("c", kc, 10, 8, cmd_c, ba_c, addr_c, done_c, prev_c);
      prev_a = cmd_a;
      prev_b = cmd_b;
      prev_c = cmd_c;
      // kc == 40 lies inside the wait after the 4th AUTO REFRESH (issued at 37)
      if (!pulsed && kc == 40) begin
        #1 rst_c = 1'b0;
        #1;
        chk_reset("c_pulse", cmd_c, ba_c, addr_c, done_c);
        pulsed = 1'b1;
        @(negedge clk_100m);
        rst_c = 1'b1;
        kc = -1;
        prev_c = NOP;
      end
    end
    chk("c_pulse_seen", 32'(pulsed), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
